// File: rtl/phtime_gate_gen.sv
// -----------------------------------------------------------------------------
// phtime_gate_gen
//
// Time base and gate sequencer for the frequency*time phase multiplier.
// Timed pulse commands {start time, length, phase-reset flag} arrive over a
// valid/ready handshake and wait in a small FIFO. Each one is scheduled against
// the free-running time counter. At its start time the gate asserts for
// 'length' cycles. tcnt is always the time elapsed since the last phase
// reference.
//
// Ports
//   i_clk          clock, all logic on posedge
//   i_reset        synchronous active-high reset
//   i_cmd_valid    command present
//   o_cmd_ready    queue not full (from registered count only)
//   i_cmd_tstart   absolute start time, compared modulo 2^TW with tnow
//   i_cmd_len      gate length in cycles, 0 = no-op
//   i_cmd_phrst    first gate cycle re-zeroes the phase reference
//   o_tnow         free-running time counter
//   o_tcnt         tnow - tphase (mod 2^TW), registered
//   o_gate         registered gate, aligned with o_tcnt
//   o_busy         queue non-empty or sequencer not idle
//   o_late_err     sticky: a command was examined after its start time
//
// Build option
//   PHTIME_GATE_LATE_DROP_EN: when defined, a late command is discarded
//   (no gate, no phase reset) instead of being started immediately.
//
// Timing: the FSM decides in the cycle where tnow == tstart. The gate and tcnt
// for that cycle are registered, so they appear one cycle later, when
// tnow == tstart + 1.
// -----------------------------------------------------------------------------
module phtime_gate_gen #(
    parameter int unsigned TW     = 27,
    parameter int unsigned LW     = 16,
    parameter int unsigned QDEPTH = 4
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_cmd_valid,
    output logic          o_cmd_ready,
    input  logic [TW-1:0] i_cmd_tstart,
    input  logic [LW-1:0] i_cmd_len,
    input  logic          i_cmd_phrst,
    output logic [TW-1:0] o_tnow,
    output logic [TW-1:0] o_tcnt,
    output logic          o_gate,
    output logic          o_busy,
    output logic          o_late_err
);

    localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] QFull = CW'(QDEPTH);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StActive = 2'd2
    } state_e;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_e        r_state;
    logic [TW-1:0] r_tnow;
    logic [TW-1:0] r_tphase;
    logic [TW-1:0] r_tcnt;
    logic          r_gate;
    logic          r_late_err;

    // Command queue storage; pointers and count are the only reset state.
    logic [TW-1:0] r_q_tstart [QDEPTH];
    logic [LW-1:0] r_q_len    [QDEPTH];
    logic          r_q_phrst  [QDEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;

    // Command currently being scheduled / played out.
    logic [TW-1:0] r_cur_tstart;
    logic [LW-1:0] r_cur_len;
    logic          r_cur_phrst;
    // Gate cycles still owed after the current one.
    logic [LW-1:0] r_rem;
    // Set in the first ACTIVE cycle of a back-to-back reloaded command.
    logic          r_first;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic          w_push;
    logic          w_pop;
    logic          w_q_empty;
    logic [TW-1:0] w_head_tstart;
    logic [LW-1:0] w_head_len;
    logic          w_head_phrst;
    logic [TW-1:0] w_tnow_inc;
    logic [TW-1:0] w_d;
    logic          w_active;
    logic [LW-1:0] w_rem_cur;
    logic          w_phrst_cur;
    logic          w_gate_src;
    logic          w_set_phase;
    logic          w_late_set;
    logic          w_load_cur;
    logic [LW-1:0] w_rem_d;
    logic          w_first_d;
    logic [TW-1:0] w_tphase_eff;
    state_e        w_state_d;

    assign w_q_empty     = (r_count == '0);
    assign o_cmd_ready   = (r_count != QFull);
    assign w_push        = i_cmd_valid & o_cmd_ready;
    assign w_head_tstart = r_q_tstart[r_rptr];
    assign w_head_len    = r_q_len[r_rptr];
    assign w_head_phrst  = r_q_phrst[r_rptr];
    assign w_tnow_inc    = r_tnow + TW'(1);
    // Signed modular distance to the start time; MSB set means late.
    assign w_d           = r_cur_tstart - r_tnow;

    // ------------------------------------------------------------------
    // Next-state / control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d   = r_state;
        w_pop       = 1'b0;
        w_load_cur  = 1'b0;
        w_active    = 1'b0;
        w_rem_cur   = r_rem;
        w_phrst_cur = 1'b0;
        w_gate_src  = 1'b0;
        w_set_phase = 1'b0;
        w_late_set  = 1'b0;
        w_rem_d     = r_rem;
        w_first_d   = 1'b0;

        case (r_state)
            StIdle: begin
                if (!w_q_empty) begin
                    // Zero-length commands are consumed here and never gate.
                    w_pop = 1'b1;
                    if (w_head_len != '0) begin
                        w_load_cur = 1'b1;
                        w_state_d  = StWait;
                    end
                end
            end
            StWait: begin
                if (w_d == '0) begin
                    w_active = 1'b1;
                end else if (w_d[TW-1]) begin
                    w_late_set = 1'b1;
`ifdef PHTIME_GATE_LATE_DROP_EN
                    w_state_d  = StIdle;
`else
                    w_active   = 1'b1;
`endif
                end
                w_rem_cur   = r_cur_len - LW'(1);
                w_phrst_cur = r_cur_phrst;
            end
            StActive: begin
                w_active    = 1'b1;
                w_rem_cur   = r_rem;
                w_phrst_cur = r_first & r_cur_phrst;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        if (w_active) begin
            w_gate_src  = 1'b1;
            w_set_phase = w_phrst_cur;
            if (w_rem_cur == '0) begin
                // Chain the next command without a gap if it starts next cycle.
                if (!w_q_empty && (w_head_tstart == w_tnow_inc) && (w_head_len != '0)) begin
                    w_pop      = 1'b1;
                    w_load_cur = 1'b1;
                    w_rem_d    = w_head_len - LW'(1);
                    w_first_d  = 1'b1;
                    w_state_d  = StActive;
                end else begin
                    w_state_d  = StIdle;
                end
            end else begin
                w_rem_d   = w_rem_cur - LW'(1);
                w_state_d = StActive;
            end
        end
    end

    // A phase reset takes effect in the same cycle so that cycle reports tcnt=0.
    assign w_tphase_eff = w_set_phase ? r_tnow : r_tphase;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_tnow       <= '0;
            r_tphase     <= '0;
            r_tcnt       <= '0;
            r_gate       <= 1'b0;
            r_late_err   <= 1'b0;
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_cur_tstart <= '0;
            r_cur_len    <= '0;
            r_cur_phrst  <= 1'b0;
            r_rem        <= '0;
            r_first      <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_tnow     <= w_tnow_inc;
            r_tphase   <= w_tphase_eff;
            r_tcnt     <= r_tnow - w_tphase_eff;
            r_gate     <= w_gate_src;
            r_late_err <= r_late_err | w_late_set;
            r_rem      <= w_rem_d;
            r_first    <= w_first_d;

            if (w_load_cur) begin
                r_cur_tstart <= w_head_tstart;
                r_cur_len    <= w_head_len;
                r_cur_phrst  <= w_head_phrst;
            end

            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue payload, no reset needed: validity is tracked by r_count.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q_tstart[r_wptr] <= i_cmd_tstart;
            r_q_len[r_wptr]    <= i_cmd_len;
            r_q_phrst[r_wptr]  <= i_cmd_phrst;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign o_tnow     = r_tnow;
    assign o_tcnt     = r_tcnt;
    assign o_gate     = r_gate;
    assign o_late_err = r_late_err;
    assign o_busy     = !w_q_empty || (r_state != StIdle);

endmodule

// File: tb/tb_phtime_gate_gen.sv
// Directed bench for phtime_gate_gen. Inputs change and outputs are sampled
// on the falling edge; the DUT registers on the rising edge.
module tb_phtime_gate_gen;

    localparam int TW     = 27;
    localparam int LW     = 16;
    localparam int QDEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_tstart;
    logic [LW-1:0] cmd_len;
    logic          cmd_phrst;
    logic [TW-1:0] tnow;
    logic [TW-1:0] tcnt;
    logic          gate;
    logic          busy;
    logic          late_err;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    phtime_gate_gen #(
        .TW     (TW),
        .LW     (LW),
        .QDEPTH (QDEPTH)
    ) u_dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_cmd_valid  (cmd_valid),
        .o_cmd_ready  (cmd_ready),
        .i_cmd_tstart (cmd_tstart),
        .i_cmd_len    (cmd_len),
        .i_cmd_phrst  (cmd_phrst),
        .o_tnow       (tnow),
        .o_tcnt       (tcnt),
        .o_gate       (gate),
        .o_busy       (busy),
        .o_late_err   (late_err)
    );

    // Reset for two rising edges; returns on the falling edge right after,
    // where the DUT shows its reset state (tnow=0).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Advance (on falling edges) until tnow equals t; bounded.
    task automatic wait_tnow(input int t);
        int n;
        logic [TW-1:0] want;
        want = TW'(t);
        n = 0;
        while (tnow !== want && n < 3000) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (tnow !== want) $display("FAIL wait_tnow: tnow=%0d required %0d", tnow, want);
        else n_pass++;
    endtask

    // Present one command during the cycle where tnow == t_at (accepted at its end).
    task automatic push(input int t_at, input int tstart, input int len, input logic phrst);
        wait_tnow(t_at);
        cmd_valid  = 1'b1;
        cmd_tstart = TW'(tstart);
        cmd_len    = LW'(len);
        cmd_phrst  = phrst;
        @(negedge clk);
        cmd_valid  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (tnow !== '0) $display("FAIL reset_tnow: got %0d required 0", tnow); else n_pass++;
        n_checks++;
        if (tcnt !== '0) $display("FAIL reset_tcnt: got %0d required 0", tcnt); else n_pass++;
        n_checks++;
        if (gate !== 1'b0) $display("FAIL reset_gate: got %b required 0", gate); else n_pass++;
        n_checks++;
        if (late_err !== 1'b0) $display("FAIL reset_late: got %b required 0", late_err);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", cmd_ready);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b required 0", busy); else n_pass++;
    endtask

    // {20,5,1}: gate visible at tnow 21..25 with tcnt 0..4.
    task automatic test_single_pulse();
        logic exp_gate;
        int   src;
        int   exp_tcnt;
        push(2, 20, 5, 1'b1);
        wait_tnow(19);
        for (int x = 19; x <= 27; x++) begin
            exp_gate = (x >= 21 && x <= 25);
            src      = x - 1;
            exp_tcnt = (src >= 20) ? src - 20 : src;
            n_checks++;
            if (tnow !== TW'(x)) $display("FAIL t1_tnow: got %0d required %0d", tnow, x);
            else n_pass++;
            n_checks++;
            if (gate !== exp_gate)
                $display("FAIL t1_gate tnow=%0d: got %b required %b", x, gate, exp_gate);
            else n_pass++;
            n_checks++;
            if (tcnt !== TW'(exp_tcnt))
                $display("FAIL t1_tcnt tnow=%0d: got %0d required %0d", x, tcnt, exp_tcnt);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (late_err !== 1'b0) $display("FAIL t1_late: got %b required 0", late_err);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL t1_busy: got %b required 0", busy); else n_pass++;
    endtask

    // {40,3,0}: phase reference stays at 20, so tcnt 20..22 at tnow 41..43.
    task automatic test_phase_hold();
        logic exp_gate;
        int   exp_tcnt;
        push(30, 40, 3, 1'b0);
        wait_tnow(38);
        for (int x = 38; x <= 46; x++) begin
            exp_gate = (x >= 41 && x <= 43);
            exp_tcnt = x - 1 - 20;
            n_checks++;
            if (gate !== exp_gate)
                $display("FAIL t2_gate tnow=%0d: got %b required %b", x, gate, exp_gate);
            else n_pass++;
            n_checks++;
            if (tcnt !== TW'(exp_tcnt))
                $display("FAIL t2_tcnt tnow=%0d: got %0d required %0d", x, tcnt, exp_tcnt);
            else n_pass++;
            @(negedge clk);
        end
    endtask

    // {100,4,1} then {104,2,0}: gate 101..106 with no gap, tcnt 0..5.
    task automatic test_back_to_back();
        logic exp_gate;
        int   src;
        int   exp_tcnt;
        push(50, 100, 4, 1'b1);
        push(52, 104, 2, 1'b0);
        wait_tnow(98);
        for (int x = 98; x <= 109; x++) begin
            exp_gate = (x >= 101 && x <= 106);
            src      = x - 1;
            exp_tcnt = (src >= 100) ? src - 100 : src - 20;
            n_checks++;
            if (gate !== exp_gate)
                $display("FAIL t3_gate tnow=%0d: got %b required %b", x, gate, exp_gate);
            else n_pass++;
            n_checks++;
            if (tcnt !== TW'(exp_tcnt))
                $display("FAIL t3_tcnt tnow=%0d: got %0d required %0d", x, tcnt, exp_tcnt);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (busy !== 1'b0) $display("FAIL t3_busy: got %b required 0", busy); else n_pass++;
    endtask

    // {5,2,0} accepted at tnow 28, examined in WAIT at tnow 30 -> late.
    task automatic test_late();
        logic exp_gate;
        logic exp_late;
        do_reset();
        push(28, 5, 2, 1'b0);
        wait_tnow(29);
        for (int x = 29; x <= 35; x++) begin
`ifdef PHTIME_GATE_LATE_DROP_EN
            exp_gate = 1'b0;
`else
            exp_gate = (x >= 31 && x <= 32);
`endif
            exp_late = (x >= 31);
            n_checks++;
            if (gate !== exp_gate)
                $display("FAIL t4_gate tnow=%0d: got %b required %b", x, gate, exp_gate);
            else n_pass++;
            n_checks++;
            if (late_err !== exp_late)
                $display("FAIL t4_late tnow=%0d: got %b required %b", x, late_err, exp_late);
            else n_pass++;
            if (exp_gate) begin
                n_checks++;
                if (tcnt !== TW'(x - 1))
                    $display("FAIL t4_tcnt tnow=%0d: got %0d required %0d", x, tcnt, x - 1);
                else n_pass++;
            end
            @(negedge clk);
        end
        // Sticky until reset.
        wait_tnow(60);
        n_checks++;
        if (late_err !== 1'b1) $display("FAIL t4_sticky: got %b required 1", late_err);
        else n_pass++;
    endtask

    // Head {200,2} waits; four zero-length entries fill the queue behind it.
    task automatic test_queue_full();
        int   accepted;
        logic exp_gate;
        logic exp_busy;
        do_reset();
        n_checks++;
        if (late_err !== 1'b0) $display("FAIL t5_late_clr: got %b required 0", late_err);
        else n_pass++;
        wait_tnow(2);
        accepted   = 0;
        cmd_valid  = 1'b1;
        cmd_tstart = TW'(200);
        cmd_len    = LW'(2);
        cmd_phrst  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (accepted >= 1) begin
                // tstart 202 == tnow+1 at the head's last cycle, but len 0 must not chain.
                cmd_tstart = TW'(202);
                cmd_len    = LW'(0);
            end
            if (cmd_ready !== 1'b1) break;
            @(posedge clk);
            accepted++;
            @(negedge clk);
        end
        n_checks++;
        if (accepted != QDEPTH + 1)
            $display("FAIL t5_accepted: got %0d required %0d", accepted, QDEPTH + 1);
        else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL t5_ready_full: got %b required 0", cmd_ready);
        else n_pass++;
        repeat (3) @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b0) $display("FAIL t5_ready_hold: got %b required 0", cmd_ready);
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL t5_busy_wait: got %b required 1", busy); else n_pass++;
        cmd_valid = 1'b0;
        wait_tnow(198);
        for (int x = 198; x <= 210; x++) begin
            exp_gate = (x >= 201 && x <= 202);
            exp_busy = (x <= 205);
            n_checks++;
            if (gate !== exp_gate)
                $display("FAIL t5_gate tnow=%0d: got %b required %b", x, gate, exp_gate);
            else n_pass++;
            n_checks++;
            if (busy !== exp_busy)
                $display("FAIL t5_busy tnow=%0d: got %b required %b", x, busy, exp_busy);
            else n_pass++;
            @(negedge clk);
        end
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL t5_ready_end: got %b required 1", cmd_ready);
        else n_pass++;
    endtask

    // Reset while test 1's pulse is on (tnow 23); a second command is queued.
    task automatic test_reset_mid_gate();
        do_reset();
        push(2, 20, 5, 1'b1);
        push(4, 200, 3, 1'b0);
        wait_tnow(23);
        n_checks++;
        if (gate !== 1'b1) $display("FAIL t6_gate_pre: got %b required 1", gate); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if (gate !== 1'b0) $display("FAIL t6_gate: got %b required 0", gate); else n_pass++;
        n_checks++;
        if (tnow !== '0) $display("FAIL t6_tnow: got %0d required 0", tnow); else n_pass++;
        n_checks++;
        if (tcnt !== '0) $display("FAIL t6_tcnt: got %0d required 0", tcnt); else n_pass++;
        n_checks++;
        if (busy !== 1'b0) $display("FAIL t6_busy: got %b required 0", busy); else n_pass++;
        n_checks++;
        if (cmd_ready !== 1'b1) $display("FAIL t6_ready: got %b required 1", cmd_ready);
        else n_pass++;
        for (int x = 1; x <= 6; x++) begin
            @(negedge clk);
            n_checks++;
            if (gate !== 1'b0 || busy !== 1'b0)
                $display("FAIL t6_idle tnow=%0d: gate=%b busy=%b required 0 0", x, gate, busy);
            else n_pass++;
            n_checks++;
            if (tcnt !== TW'(x - 1))
                $display("FAIL t6_tcnt_run tnow=%0d: got %0d required %0d", x, tcnt, x - 1);
            else n_pass++;
        end
    endtask

    initial begin
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_tstart = '0;
        cmd_len    = '0;
        cmd_phrst  = 1'b0;
        test_reset();
        test_single_pulse();
        test_phase_hold();
        test_back_to_back();
        test_late();
        test_queue_full();
        test_reset_mid_gate();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
